// File: rtl/cga_de_gen_pkg.sv
// Shared constants and types for the CGA display-enable generator.
// Default timing matches a 640x200 CGA mode sampled at the pixel clock.
package cga_de_gen_pkg;

    localparam int IRGB_I = 3;
    localparam int IRGB_R = 2;
    localparam int IRGB_G = 1;
    localparam int IRGB_B = 0;

    localparam int HPOS_W = 12;
    localparam int VPOS_W = 10;

    localparam logic [HPOS_W-1:0] CGA_H_BACK   = 12'd72;
    localparam logic [HPOS_W-1:0] CGA_H_ACTIVE = 12'd640;
    localparam logic [VPOS_W-1:0] CGA_V_BACK   = 10'd16;
    localparam logic [VPOS_W-1:0] CGA_V_ACTIVE = 10'd200;

    typedef struct packed {
        logic [3:0] video;
        logic       hs;
        logic       vs;
    } vid_sample_t;

endpackage

// File: rtl/cga_sync_counter.sv
// Sync edge detection and saturating pixel/line position counters.
// hpos/vpos describe the sample one stage behind s1; hs_fall is for the current s1 sample.
module cga_sync_counter
    import cga_de_gen_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s1_hs,
    input  logic              s1_vs,
    output logic [HPOS_W-1:0] hpos,
    output logic [VPOS_W-1:0] vpos,
    output logic              hs_fall
);

    logic              prev_hs_q, prev_hs_d;
    logic              prev_vs_q, prev_vs_d;
    logic [HPOS_W-1:0] hpos_q, hpos_d;
    logic [VPOS_W-1:0] vpos_q, vpos_d;
    logic              vs_fall;

    always_comb begin
        hs_fall   = prev_hs_q & ~s1_hs;
        vs_fall   = prev_vs_q & ~s1_vs;
        prev_hs_d = s1_hs;
        prev_vs_d = s1_vs;

        hpos_d = hpos_q;
        if (hs_fall) begin
            hpos_d = '0;
        end else if (hpos_q != {HPOS_W{1'b1}}) begin
            hpos_d = hpos_q + 1'b1;
        end

        // A frame restart wins over a line restart on the same sample.
        vpos_d = vpos_q;
        if (vs_fall) begin
            vpos_d = '0;
        end else if (hs_fall && (vpos_q != {VPOS_W{1'b1}})) begin
            vpos_d = vpos_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_hs_q <= 1'b0;
            prev_vs_q <= 1'b0;
            hpos_q    <= {HPOS_W{1'b1}};
            vpos_q    <= {VPOS_W{1'b1}};
        end else begin
            prev_hs_q <= prev_hs_d;
            prev_vs_q <= prev_vs_d;
            hpos_q    <= hpos_d;
            vpos_q    <= vpos_d;
        end
    end

    assign hpos = hpos_q;
    assign vpos = vpos_q;

endmodule

// File: rtl/cga_de_gen.sv
// Derives display enable from CGA sync timing, blanks video outside it,
// and presents video/syncs/DE aligned with a fixed two-clock latency.
module cga_de_gen
    import cga_de_gen_pkg::*;
#(
    parameter logic [HPOS_W-1:0] H_BACK     = CGA_H_BACK,
    parameter logic [HPOS_W-1:0] H_ACTIVE   = CGA_H_ACTIVE,
    parameter logic [VPOS_W-1:0] V_BACK     = CGA_V_BACK,
    parameter logic [VPOS_W-1:0] V_ACTIVE   = CGA_V_ACTIVE,
    parameter logic [HPOS_W-1:0] H_TIMEOUT  = 12'd1200,
    parameter logic [2:0]        LOCK_LINES = 3'd4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] video_in,
    input  logic       hsync_in,
    input  logic       vsync_in,
    output logic [3:0] video_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       display_enable,
    output logic       sync_ok
);

    localparam logic [HPOS_W-1:0] H_END        = H_BACK + H_ACTIVE;
    localparam logic [VPOS_W-1:0] V_END        = V_BACK + V_ACTIVE;
    localparam logic [HPOS_W-1:0] H_TIMEOUT_M1 = H_TIMEOUT - 12'd1;

    vid_sample_t       s1_q, s1_d;
    vid_sample_t       s2_q, s2_d;
    logic [2:0]        lock_cnt_q, lock_cnt_d;
    logic [3:0]        video_out_q, video_out_d;
    logic              hsync_out_q, hsync_out_d;
    logic              vsync_out_q, vsync_out_d;
    logic              de_q, de_d;
    logic              sync_ok_q, sync_ok_d;

    logic [HPOS_W-1:0] hpos;
    logic [VPOS_W-1:0] vpos;
    logic              hs_fall;
    logic              locked;

    cga_sync_counter u_sync_counter (
        .clk     (clk),
        .reset_n (reset_n),
        .s1_hs   (s1_q.hs),
        .s1_vs   (s1_q.vs),
        .hpos    (hpos),
        .vpos    (vpos),
        .hs_fall (hs_fall)
    );

    always_comb begin
        s1_d.video = video_in;
        s1_d.hs    = hsync_in;
        s1_d.vs    = vsync_in;
        s2_d       = s1_q;

        // hpos here is the previous sample's position, i.e. the length of the
        // line that just ended. A value already past timeout (including the
        // post-reset 0xFFF) means no valid period preceded this edge.
        lock_cnt_d = lock_cnt_q;
        if (hs_fall) begin
            if ((hpos < H_TIMEOUT) && (lock_cnt_q < LOCK_LINES)) begin
                lock_cnt_d = lock_cnt_q + 3'd1;
            end
        end else if (hpos == H_TIMEOUT_M1) begin
            lock_cnt_d = 3'd0;
        end

        // Window and lock are evaluated for the sample now in stage 2.
        locked      = (lock_cnt_q == LOCK_LINES);
        de_d        = locked && (hpos >= H_BACK) && (hpos < H_END)
                             && (vpos >= V_BACK) && (vpos < V_END);
        video_out_d = de_d ? s2_q.video : 4'h0;
        hsync_out_d = s2_q.hs;
        vsync_out_d = s2_q.vs;
        sync_ok_d   = locked;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_q        <= '0;
            s2_q        <= '0;
            lock_cnt_q  <= 3'd0;
            video_out_q <= 4'h0;
            hsync_out_q <= 1'b0;
            vsync_out_q <= 1'b0;
            de_q        <= 1'b0;
            sync_ok_q   <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            lock_cnt_q  <= lock_cnt_d;
            video_out_q <= video_out_d;
            hsync_out_q <= hsync_out_d;
            vsync_out_q <= vsync_out_d;
            de_q        <= de_d;
            sync_ok_q   <= sync_ok_d;
        end
    end

    assign video_out      = video_out_q;
    assign hsync_out      = hsync_out_q;
    assign vsync_out      = vsync_out_q;
    assign display_enable = de_q;
    assign sync_ok        = sync_ok_q;

endmodule

// File: tb/tb_cga_de_gen.sv
// Bench for cga_de_gen: table of line segments with expected lock/DE totals,
// plus a timestamp-based reference model checked on every output cycle.
module tb_cga_de_gen;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] video_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [3:0] video_out;
    logic       hsync_out;
    logic       vsync_out;
    logic       display_enable;
    logic       sync_ok;

    always #5 clk = ~clk;

    cga_de_gen dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .video_in       (video_in),
        .hsync_in       (hsync_in),
        .vsync_in       (vsync_in),
        .video_out      (video_out),
        .hsync_out      (hsync_out),
        .vsync_out      (vsync_out),
        .display_enable (display_enable),
        .sync_ok        (sync_ok)
    );

    // Reference timing values written out independently of the design.
    localparam int T_HB = 72, T_HA = 640, T_VB = 16, T_VA = 200;
    localparam int T_TO = 1200, T_LOCK = 4;

    int n_cmp  = 0;
    int n_fail = 0;
    int seg_de = 0;

    // Scoreboard: expected {video, hs, vs, de, ok} per output cycle.
    logic [7:0] exp_q[$];

    // Model state: absolute sample index of the last hsync fall and the
    // number of hsync falls since the last vsync fall (-1 = never seen).
    int m_now, m_last_hf, m_lines, m_cnt;
    bit m_prev_hs, m_prev_vs;

    task automatic model_reset();
        m_prev_hs = 0;
        m_prev_vs = 0;
        m_last_hf = -1;
        m_lines   = -1;
        m_cnt     = 0;
    endtask

    task automatic model_step(input logic [3:0] v, input logic hs, input logic vs,
                              output logic [7:0] e);
        bit hf, vf, ok, de;
        int prev_h, h, vp;
        m_now  = m_now + 1;
        hf     = m_prev_hs && !hs;
        vf     = m_prev_vs && !vs;
        prev_h = (m_last_hf < 0) ? 4095 : ((m_now - 1 - m_last_hf) > 4095 ? 4095 : (m_now - 1 - m_last_hf));
        if (hf) m_last_hf = m_now;
        h = (m_last_hf < 0) ? 4095 : ((m_now - m_last_hf) > 4095 ? 4095 : (m_now - m_last_hf));
        if (vf) m_lines = 0;
        else if (hf && m_lines >= 0) m_lines = m_lines + 1;
        vp = (m_lines < 0) ? 1023 : (m_lines > 1023 ? 1023 : m_lines);
        if (hf) begin
            if (prev_h < T_TO && m_cnt < T_LOCK) m_cnt = m_cnt + 1;
        end else if (h == T_TO) begin
            m_cnt = 0;
        end
        ok = (m_cnt == T_LOCK);
        de = ok && h >= T_HB && h < T_HB + T_HA && vp >= T_VB && vp < T_VB + T_VA;
        m_prev_hs = hs;
        m_prev_vs = vs;
        e = {de ? v : 4'h0, hs, vs, de, ok};
    endtask

    task automatic drive_cycle(input logic rst, input logic [3:0] v, input logic hs, input logic vs);
        logic [7:0] e, act;
        reset_n  = !rst;
        video_in = v;
        hsync_in = hs;
        vsync_in = vs;
        @(posedge clk);
        if (rst) begin
            model_reset();
            exp_q.delete();
            exp_q.push_back(8'h00);
            exp_q.push_back(8'h00);
            e = 8'h00;
        end else begin
            model_step(v, hs, vs, e);
            exp_q.push_back(e);
            e = exp_q.pop_front();
        end
        #1;
        act = {video_out, hsync_out, vsync_out, display_enable, sync_ok};
        n_cmp = n_cmp + 1;
        if (act !== e) begin
            n_fail = n_fail + 1;
            $display("FAIL model t=%0t got {v,hs,vs,de,ok}=%h required %h", $time, act, e);
        end
        if (display_enable === 1'b1) seg_de = seg_de + 1;
    endtask

    typedef struct {
        string name;
        int    n_lines;
        int    line_len;
        int    hs_w;
        int    vs_mode;   // 0 low, 1 high whole line, 2 high together with hsync
        int    rst_at;    // sample index of a 2-cycle reset pulse, -1 none
        bit    rand_vid;
        bit    chk;
        bit    exp_ok;
        int    exp_de;
    } seg_t;

    task automatic run_seg(input seg_t s);
        logic [3:0] v;
        logic hs, vs, rst;
        seg_de = 0;
        for (int l = 0; l < s.n_lines; l++) begin
            for (int i = 0; i < s.line_len; i++) begin
                hs  = (i < s.hs_w);
                vs  = (s.vs_mode == 1) ? 1'b1 : (s.vs_mode == 2) ? (i < s.hs_w) : 1'b0;
                v   = s.rand_vid ? 4'($urandom_range(0, 15)) : 4'hA;
                rst = (s.rst_at >= 0) && (i >= s.rst_at) && (i < s.rst_at + 2);
                drive_cycle(rst, v, hs, vs);
            end
        end
        if (s.chk) begin
            n_cmp = n_cmp + 1;
            if (sync_ok !== s.exp_ok) begin
                n_fail = n_fail + 1;
                $display("FAIL %s_sync_ok got %b required %b", s.name, sync_ok, s.exp_ok);
            end
            n_cmp = n_cmp + 1;
            if (seg_de != s.exp_de) begin
                n_fail = n_fail + 1;
                $display("FAIL %s_de_count got %0d required %0d", s.name, seg_de, s.exp_de);
            end
        end
    endtask

    seg_t segs[13];
    seg_t rs;

    initial begin
        segs[0]  = '{"lock_pre",    4,  912, 64, 0,  -1, 0, 1, 0, 0};
        segs[1]  = '{"lock",        1,  912, 64, 0,  -1, 0, 1, 1, 0};
        segs[2]  = '{"vs_line",     1,  912, 64, 1,  -1, 0, 1, 1, 0};
        segs[3]  = '{"active",      20, 912, 64, 0,  -1, 0, 1, 1, 3200};
        segs[4]  = '{"timeout",     1, 1400, 0,  0,  -1, 0, 1, 0, 0};
        segs[5]  = '{"relock_pre",  4,  912, 64, 0,  -1, 0, 1, 0, 0};
        segs[6]  = '{"relock",      1,  912, 64, 0,  -1, 0, 1, 1, 640};
        segs[7]  = '{"early_hs",    1,  300, 64, 0,  -1, 0, 1, 1, 162};
        segs[8]  = '{"after_early", 1,  912, 64, 0,  -1, 0, 1, 1, 706};
        segs[9]  = '{"vs_hs_same",  1,  912, 64, 2,  -1, 0, 1, 1, 0};
        segs[10] = '{"vpos_1_15",   15, 912, 64, 0,  -1, 0, 1, 1, 0};
        segs[11] = '{"vpos_16",     1,  912, 64, 0,  -1, 0, 1, 1, 640};
        segs[12] = '{"mid_reset",   1,  912, 64, 0, 400, 0, 1, 0, 262};

        m_now = 0;
        model_reset();

        // Reset held for 3 clocks with busy inputs: outputs must stay at zero.
        for (int k = 0; k < 3; k++) begin
            drive_cycle(1'b1, 4'hF, 1'b1, 1'b0);
            n_cmp = n_cmp + 1;
            if ({video_out, hsync_out, vsync_out, display_enable, sync_ok} !== 8'h00) begin
                n_fail = n_fail + 1;
                $display("FAIL reset_outputs got %h required 00",
                         {video_out, hsync_out, vsync_out, display_enable, sync_ok});
            end
        end

        foreach (segs[k]) run_seg(segs[k]);

        // Randomised lines, checked cycle by cycle against the model only.
        for (int k = 0; k < 16; k++) begin
            rs.name     = "random";
            rs.n_lines  = 1;
            rs.line_len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(300, 1300)) : 912;
            rs.hs_w     = $urandom_range(20, 100);
            rs.vs_mode  = ($urandom_range(0, 7) == 0) ? 1 : (($urandom_range(0, 7) == 0) ? 2 : 0);
            rs.rst_at   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 250)) : -1;
            rs.rand_vid = 1;
            rs.chk      = 0;
            rs.exp_ok   = 0;
            rs.exp_de   = 0;
            run_seg(rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/cga_de_gen.md
Name: cga_de_gen

Overview:
- Sits directly upstream of the CGA-to-HDMI output port.
- Takes raw CGA digital video (IRGB) and sync, derives the display-enable window by counting pixel clocks from sync edges, and blanks video outside that window.
- Delivers video, syncs and display_enable aligned to each other with a fixed latency, so the output port can register them unchanged.

Parameters:
- H_BACK, 12'd72: pixel clocks from the hsync falling-edge sample (hpos=0) to the first active pixel.
- H_ACTIVE, 12'd640: active pixels per line.
- V_BACK, 10'd16: lines from the vsync falling edge (vpos=0) to the first active line.
- V_ACTIVE, 10'd200: active lines per frame.
- H_TIMEOUT, 12'd1200: hpos value at which the line is declared lost.
- LOCK_LINES, 3'd4: consecutive good lines required before sync_ok rises.

Ports:
- clk  in  1  pixel clock; all logic on posedge.
- reset_n  in  1  synchronous active-low reset.
- video_in  in  4  raw IRGB (bit3 I, bit2 R, bit1 G, bit0 B).
- hsync_in  in  1  raw CGA hsync, active high.
- vsync_in  in  1  raw CGA vsync, active high.
- video_out  out  4  IRGB, forced to 4'h0 when display_enable=0.
- hsync_out  out  1  hsync_in delayed 2 clk.
- vsync_out  out  1  vsync_in delayed 2 clk.
- display_enable  out  1  active-area flag.
- sync_ok  out  1  line timing locked.

Behaviour:
- Latency: an input sample presented at edge N appears on all outputs after edge N+2. All outputs are registered and aligned; there is no combinational path from input to output.
- Stage 1 registers the inputs (s1_*) and keeps the previous hsync/vsync samples for edge detection.
  - hs_fall = prev_hs & ~s1_hs.
  - vs_fall = prev_vs & ~s1_vs.
- hpos (12-bit):
  - 0 on a sample with hs_fall.
  - Otherwise hpos+1, saturating at 12'hFFF.
- vpos (10-bit):
  - 0 on a sample with vs_fall; vs_fall has priority over a simultaneous hs_fall.
  - Otherwise +1 on each hs_fall, saturating at 10'h3FF.
- DE for a sample requires all of:
  - sync_ok=1;
  - H_BACK <= hpos < H_BACK+H_ACTIVE;
  - V_BACK <= vpos < V_BACK+V_ACTIVE.
  - Comparisons are unsigned at counter width. Parameter sums must fit their width; exceeding it is a parameter error that is not checked in RTL.
- Blanking: video_out = DE ? sample video : 4'h0.
- Lock logic (3-bit good-line count):
  - On hs_fall with previous hpos < H_TIMEOUT: count increments, saturating at LOCK_LINES. sync_ok=1 once count equals LOCK_LINES.
  - When hpos reaches H_TIMEOUT: count=0 and sync_ok=0 on the same cycle that hpos reaches it.
  - The first hs_fall after reset or timeout does not count, because no valid period preceded it.
- An early hsync (hs_fall mid-active) restarts hpos at 0, so DE drops on that sample's output. No error is flagged beyond normal counting.
- Missing vsync: vpos saturates at 1023 and DE stays low until the next vs_fall.
- Reset (synchronous, reset_n=0 at posedge) clears:
  - all pipeline regs, prev_hs, prev_vs, and the lock count to 0;
  - hpos to 12'hFFF and vpos to 10'h3FF.
  - Result: outputs video_out=0, hsync_out=0, vsync_out=0, display_enable=0, sync_ok=0 on the edge after reset is sampled.
  - Reset asserted mid-line behaves identically and discards in-flight samples.
  - Because prev_hs=0 after reset, an hsync low at reset release is not an edge.

Decomposition:
- Shared package holds:
  - IRGB bit-index constants (I=3, R=2, G=1, B=0);
  - the width constants HPOS_W=12 and VPOS_W=10;
  - the default CGA timing constants (H_BACK, H_ACTIVE, V_BACK, V_ACTIVE).
- One sub-module is natural: cga_sync_counter. It contains the edge detect plus the saturating hpos/vpos counters and outputs hpos, vpos and hs_fall.
- The top keeps lock logic, window compare, blanking and the delay pipeline.

Test Plan:
- Reset: hold reset_n=0 for 3 clk with video_in=4'hF and hsync_in=1 -> all outputs 0; hpos=0xFFF after release; no DE.
- Nominal lock: lines of 912 clk with hsync high for 64 clk, 5 lines -> sync_ok rises on the 5th hs_fall (4th good period); prev count 0..3 keeps it low.
- Active window: after lock, vs_fall then 20 lines of video_in=4'hA -> display_enable high exactly for hpos 72..711 on vpos 16..; video_out=4'hA there and 4'h0 elsewhere; all outputs shifted 2 clk from input.
- Timeout: stop hsync for 1300 clk after lock -> sync_ok and display_enable fall on the cycle whose output sample has hpos=1200; relock needs 4 further good lines.
- Early hsync: hs_fall at hpos=300 inside active -> display_enable low on that output sample; next pixel hpos=1; the line counts as good (period 300 < 1200).
- Simultaneous vs_fall and hs_fall on one sample -> vpos=0, not 1; DE starts at vpos 16 as normal.
